// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg -- shared CPU definitions for the fetch stage.
// Holds the program-counter and instruction widths, the opcodes that the
// fetch stage handles itself (jmp, br), the fetch FSM state encoding and
// a wrapping program-counter increment helper.
package fetch_unit_pkg;

    localparam int PC_W    = 4;
    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_JMP = 4'b1000;
    localparam logic [3:0] OP_BR  = 4'b1100;

    // S_ILLEGAL is never entered on purpose; it exists so the recovery
    // path back to S_FETCH has a name.
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_ISSUE   = 2'd1,
        S_BRANCH  = 2'd2,
        S_ILLEGAL = 2'd3
    } state_e;

    // Next sequential address; wraps 15 -> 0 through natural overflow.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc_i);
        return pc_i + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- bundle of the fetch stage's ROM and execute-side signals.
//   pc          : ROM address (fetch unit -> ROM)
//   rom_data    : combinational ROM word at pc (ROM -> fetch unit)
//   instr       : registered issued instruction (fetch unit -> execute)
//   instr_valid : instr holds an instruction for execute
//   instr_ready : execute accepts instr this cycle
//   flag_valid  : execute has retired every accepted instruction
//   zero_flag   : last retired result was zero
//   state_dbg   : current fetch FSM state
//   step        : single-step enable, present only when FETCH_STEP_EN is defined
// master = fetch unit side, slave = ROM/execute side.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic               flag_valid;
    logic               zero_flag;
    logic [1:0]         state_dbg;
`ifdef FETCH_STEP_EN
    logic               step;
`endif

    modport master (
        input  rom_data, instr_ready, flag_valid, zero_flag,
`ifdef FETCH_STEP_EN
        input  step,
`endif
        output pc, instr, instr_valid, state_dbg
    );

    modport slave (
        output rom_data, instr_ready, flag_valid, zero_flag,
`ifdef FETCH_STEP_EN
        output step,
`endif
        input  pc, instr, instr_valid, state_dbg
    );

endinterface

// File: rtl/fetch_decode.sv
// fetch_decode -- combinational decode of the control-flow opcodes.
//   word_hi : upper byte of the ROM word ({opcode, target})
//   is_jmp  : opcode is jmp
//   is_br   : opcode is br
//   target  : branch/jump target address field
module fetch_decode
    import fetch_unit_pkg::*;
(
    input  logic [7:0]      word_hi,
    output logic            is_jmp,
    output logic            is_br,
    output logic [PC_W-1:0] target
);

    // Opcode match and target extraction; every other opcode is issued.
    always_comb begin
        is_jmp = 1'b0;
        is_br  = 1'b0;
        target = word_hi[3:0];
        case (word_hi[7:4])
            OP_JMP:  is_jmp = 1'b1;
            OP_BR:   is_br  = 1'b1;
            default: begin
                is_jmp = 1'b0;
                is_br  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with jmp/br handling.
// Fetches from a combinational ROM at pc, resolves jmp in one cycle, holds
// br until execute reports flags, and issues every other opcode to execute
// through a valid/ready handshake.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : fetch_unit_if.master (pc, rom_data, instr, instr_valid,
//          instr_ready, flag_valid, zero_flag, state_dbg[, step])
// Optional: define FETCH_STEP_EN to add bus.step; FETCH then advances only
// on cycles where step=1 (ISSUE and BRANCH are not gated).
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    target_q, target_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;

    logic               is_jmp_s;
    logic               is_br_s;
    logic [PC_W-1:0]    dec_target_s;
    logic               advance_s;

    fetch_decode u_decode (
        .word_hi (bus.rom_data[INSTR_W-1:INSTR_W-8]),
        .is_jmp  (is_jmp_s),
        .is_br   (is_br_s),
        .target  (dec_target_s)
    );

`ifdef FETCH_STEP_EN
    assign advance_s = bus.step;
`else
    assign advance_s = 1'b1;
`endif

    // Next-state, pc, instruction register and latched branch target.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        target_d      = target_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            S_FETCH: begin
                // The word at pc is captured every resident cycle, even when
                // it turns out to be jmp/br; instr_valid stays low for those.
                instr_d       = bus.rom_data;
                instr_valid_d = 1'b0;
                if (advance_s) begin
                    if (is_jmp_s) begin
                        pc_d = dec_target_s;
                    end else if (is_br_s) begin
                        target_d = dec_target_s;
                        state_d  = S_BRANCH;
                    end else begin
                        pc_d          = pc_inc(pc_q);
                        instr_valid_d = 1'b1;
                        state_d       = S_ISSUE;
                    end
                end else begin
                    pc_d = pc_q;
                end
            end
            S_ISSUE: begin
                if (instr_valid_q && bus.instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_FETCH;
                end else begin
                    instr_valid_d = 1'b1;
                end
            end
            S_BRANCH: begin
                if (bus.flag_valid) begin
                    pc_d    = bus.zero_flag ? target_q : pc_inc(pc_q);
                    state_d = S_FETCH;
                end else begin
                    state_d = S_BRANCH;
                end
            end
            default: begin
                // Unreachable encoding: drop anything pending and refetch.
                instr_valid_d = 1'b0;
                state_d       = S_FETCH;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= {PC_W{1'b0}};
            target_q      <= {PC_W{1'b0}};
            instr_q       <= {INSTR_W{1'b0}};
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            target_q      <= target_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.state_dbg   = state_q;

endmodule
